// File: rtl/p4_router_ing_port_adapter_if.sv
// AXI-Stream bundle shared by the narrow physical-port side and the wide ingress-buffer side
// of the P4 router ingress port adapter.
interface p4_router_ing_port_adapter_if #(
   parameter int DATA_BYTES = 8,
   parameter int ID_WIDTH   = 4,
   parameter int DEST_WIDTH = 4,
   parameter int USER_WIDTH = 1
);
   logic [DATA_BYTES*8-1:0] tdata;
   logic [DATA_BYTES-1:0]   tkeep;
   logic [DATA_BYTES-1:0]   tstrb;
   logic                    tlast;
   logic                    tvalid;
   logic                    tready;
   logic [ID_WIDTH-1:0]     tid;
   logic [DEST_WIDTH-1:0]   tdest;
   logic [USER_WIDTH-1:0]   tuser;

   modport master (
      output tdata, tkeep, tstrb, tlast, tvalid, tid, tdest, tuser,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tstrb, tlast, tvalid, tid, tdest, tuser,
      output tready
   );
endinterface

// File: rtl/p4_router_ing_port_adapter.sv
// Packs narrow physical-port AXIS beats into full-width ingress-buffer words, checks tkeep and
// counts packets/runts. Define P4_ROUTER_ING_RUNT_PAD_EN to pad runts with zero bytes up to MIN_PKT_BYTES.
module p4_router_ing_port_adapter #(
   parameter int IN_BYTES      = 8,
   parameter int OUT_BYTES     = 32,
   parameter int MIN_PKT_BYTES = 64,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                          clk,
   input  logic                          areset,
   p4_router_ing_port_adapter_if.slave   phys_port,
   p4_router_ing_port_adapter_if.master  adapted,
   output logic [CNT_WIDTH-1:0]          pkt_cnt,
   output logic [CNT_WIDTH-1:0]          runt_cnt,
   output logic                          keep_err
);

   localparam int RATIO    = OUT_BYTES / IN_BYTES;
   localparam int IN_BITS  = IN_BYTES * 8;
   localparam int OUT_BITS = OUT_BYTES * 8;
   localparam int LANE_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int BCNT_W   = $clog2(MIN_PKT_BYTES + 1);
   localparam logic [BCNT_W:0]   MIN_W   = (BCNT_W+1)'(MIN_PKT_BYTES);
   localparam logic [BCNT_W-1:0] MIN_SAT = BCNT_W'(MIN_PKT_BYTES);

`ifdef P4_ROUTER_ING_RUNT_PAD_EN
   typedef enum logic [0:0] {ACCUM = 1'b0, PAD = 1'b1} state_t;
`else
   typedef enum logic [0:0] {ACCUM = 1'b0} state_t;
`endif

   function automatic logic [IN_BYTES-1:0] in_prefix(input int n);
      logic [IN_BYTES-1:0] m;
      m = '0;
      for (int i = 0; i < IN_BYTES; i++) m[i] = (i < n);
      return m;
   endfunction

   function automatic logic [OUT_BYTES-1:0] out_prefix(input int n);
      logic [OUT_BYTES-1:0] m;
      m = '0;
      for (int i = 0; i < OUT_BYTES; i++) m[i] = (i < n);
      return m;
   endfunction

   state_t                state, state_next;
   logic [OUT_BITS-1:0]   a_data, o_data, word_data, o_load_data;
   logic [OUT_BYTES-1:0]  a_keep, o_keep, word_keep, o_load_keep;
   logic [LANE_W-1:0]     lane;
   logic                  o_valid, o_last, o_load, o_load_last;
   logic [BCNT_W-1:0]     byte_cnt, byte_next;
   logic [BCNT_W:0]       byte_sum;
   logic [IN_BYTES-1:0]   eff_keep;
   logic [IN_BITS-1:0]    beat_data;
   logic                  keep_contig, keep_bad, beat_done, o_free, in_ready, accept, is_runt;
   logic                  unused_in;
`ifdef P4_ROUTER_ING_RUNT_PAD_EN
   logic [BCNT_W-1:0]     wb, wb_next, pad_rem, pad_rem_next;
   logic [BCNT_W:0]       covered;
`endif

   assign unused_in = ^{phys_port.tstrb, phys_port.tid, phys_port.tdest, phys_port.tuser};

   // Beat qualification: sanitise tkeep, place the beat in its lane and track packet length.
   always_comb begin
      keep_contig = (phys_port.tkeep != '0) &&
                    ((phys_port.tkeep & (phys_port.tkeep + IN_BYTES'(1))) == '0);
      keep_bad    = phys_port.tlast ? !keep_contig : (phys_port.tkeep != '1);
      eff_keep    = phys_port.tlast ? in_prefix($countones(phys_port.tkeep)) : '1;
      beat_data   = '0;
      for (int i = 0; i < IN_BYTES; i++)
         if (eff_keep[i]) beat_data[i*8 +: 8] = phys_port.tdata[i*8 +: 8];
      word_data   = a_data | (OUT_BITS'(beat_data) << (int'(lane) * IN_BITS));
      word_keep   = a_keep | (OUT_BYTES'(eff_keep) << (int'(lane) * IN_BYTES));
      beat_done   = phys_port.tlast || (lane == LANE_W'(RATIO - 1));
      o_free      = !o_valid || adapted.tready;
      in_ready    = (state == ACCUM) && (!beat_done || o_free);
      accept      = phys_port.tvalid && in_ready;
      byte_sum    = {1'b0, byte_cnt} + (BCNT_W+1)'($countones(eff_keep));
      byte_next   = (byte_sum >= MIN_W) ? MIN_SAT : byte_sum[BCNT_W-1:0];
      is_runt     = byte_sum < MIN_W;
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) state <= ACCUM;
      else        state <= state_next;
   end

   // Next state and the word to load into the output register this cycle.
   always_comb begin
      state_next  = state;
      o_load      = 1'b0;
      o_load_data = word_data;
      o_load_keep = word_keep;
      o_load_last = phys_port.tlast;
`ifdef P4_ROUTER_ING_RUNT_PAD_EN
      wb_next      = wb;
      pad_rem_next = pad_rem;
      covered      = {1'b0, wb} + (BCNT_W+1)'(OUT_BYTES);
`endif
      case (state)
         ACCUM: begin
            if (accept && beat_done) begin
               o_load = 1'b1;
`ifdef P4_ROUTER_ING_RUNT_PAD_EN
               if (phys_port.tlast) begin
                  wb_next = '0;
                  if (is_runt) begin
                     if (covered >= MIN_W) begin
                        o_load_keep = out_prefix(MIN_PKT_BYTES - int'(wb));
                     end else begin
                        o_load_keep  = '1;
                        o_load_last  = 1'b0;
                        state_next   = PAD;
                        pad_rem_next = BCNT_W'(MIN_W - covered);
                     end
                  end
               end else begin
                  wb_next = (covered >= MIN_W) ? MIN_SAT : covered[BCNT_W-1:0];
               end
`endif
            end
         end
`ifdef P4_ROUTER_ING_RUNT_PAD_EN
         PAD: begin
            if (o_free) begin
               o_load      = 1'b1;
               o_load_data = '0;
               if (pad_rem > BCNT_W'(OUT_BYTES)) begin
                  o_load_keep  = '1;
                  o_load_last  = 1'b0;
                  pad_rem_next = pad_rem - BCNT_W'(OUT_BYTES);
               end else begin
                  o_load_keep  = out_prefix(int'(pad_rem));
                  o_load_last  = 1'b1;
                  state_next   = ACCUM;
               end
            end
         end
`endif
         default: state_next = ACCUM;
      endcase
   end

   // Assembly register, output register and statistics.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         a_data   <= '0;
         a_keep   <= '0;
         lane     <= '0;
         o_data   <= '0;
         o_keep   <= '0;
         o_last   <= 1'b0;
         o_valid  <= 1'b0;
         byte_cnt <= '0;
         pkt_cnt  <= '0;
         runt_cnt <= '0;
         keep_err <= 1'b0;
`ifdef P4_ROUTER_ING_RUNT_PAD_EN
         wb       <= '0;
         pad_rem  <= '0;
`endif
      end else begin
         keep_err <= accept && keep_bad;
         if (accept) begin
            if (beat_done) begin
               a_data <= '0;
               a_keep <= '0;
               lane   <= '0;
            end else begin
               a_data <= word_data;
               a_keep <= word_keep;
               lane   <= lane + LANE_W'(1);
            end
            byte_cnt <= phys_port.tlast ? '0 : byte_next;
            if (phys_port.tlast && is_runt) runt_cnt <= runt_cnt + 1'b1;
         end
         if (o_load) begin
            o_valid <= 1'b1;
            o_data  <= o_load_data;
            o_keep  <= o_load_keep;
            o_last  <= o_load_last;
         end else if (adapted.tready) begin
            o_valid <= 1'b0;
         end
         if (o_valid && adapted.tready && o_last) pkt_cnt <= pkt_cnt + 1'b1;
`ifdef P4_ROUTER_ING_RUNT_PAD_EN
         wb      <= wb_next;
         pad_rem <= pad_rem_next;
`endif
      end
   end

   assign phys_port.tready = in_ready;
   assign adapted.tvalid   = o_valid;
   assign adapted.tdata    = o_data;
   assign adapted.tkeep    = o_keep;
   assign adapted.tlast    = o_last;
   assign adapted.tstrb    = '1;
   assign adapted.tid      = '0;
   assign adapted.tdest    = '0;
   assign adapted.tuser    = '0;

endmodule

// File: tb/tb_p4_router_ing_port_adapter.sv
// Self-checking bench for p4_router_ing_port_adapter: packet vectors against a byte-level
// scoreboard, plus tkeep-violation, back-pressure and mid-packet reset sequences.
module tb_p4_router_ing_port_adapter;

   localparam int IN_B  = 8;
   localparam int OUT_B = 32;
   localparam int MIN_B = 64;

   typedef struct packed {
      logic [OUT_B*8-1:0] data;
      logic [OUT_B-1:0]   keep;
      logic               last;
   } exp_word_t;

   typedef struct {
      int len;
      int seed;
      int exp_words;
      int exp_runt_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic areset;
   logic [31:0] pkt_cnt, runt_cnt;
   logic keep_err;

   p4_router_ing_port_adapter_if #(.DATA_BYTES(IN_B))  phys_port ();
   p4_router_ing_port_adapter_if #(.DATA_BYTES(OUT_B)) adapted ();

   p4_router_ing_port_adapter #(
      .IN_BYTES(IN_B), .OUT_BYTES(OUT_B), .MIN_PKT_BYTES(MIN_B), .CNT_WIDTH(32)
   ) dut (
      .clk(clk), .areset(areset), .phys_port(phys_port), .adapted(adapted),
      .pkt_cnt(pkt_cnt), .runt_cnt(runt_cnt), .keep_err(keep_err)
   );

   always #5 clk = ~clk;

   exp_word_t exp_q[$];
   int n_total = 0;
   int n_pass = 0;
   int words_seen = 0;
   int keep_err_seen = 0;
   logic stall_mode = 1'b0;
   logic held_valid = 1'b0;
   logic [OUT_B*8-1:0] held_data;
   logic [OUT_B+1:0] held_ctrl;

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [7:0] byte_val(input int seed, input int idx);
      return 8'((seed * 31 + idx * 7 + 3) & 255);
   endfunction

   task automatic pushExpected(input int len, input int seed);
      exp_word_t e;
      int tot, nw, idx;
      tot = len;
`ifdef P4_ROUTER_ING_RUNT_PAD_EN
      if (tot < MIN_B) tot = MIN_B;
`endif
      nw = (tot + OUT_B - 1) / OUT_B;
      for (int w = 0; w < nw; w++) begin
         e.data = '0;
         e.keep = '0;
         for (int j = 0; j < OUT_B; j++) begin
            idx = w * OUT_B + j;
            if (idx < tot) e.keep[j] = 1'b1;
            if (idx < len) e.data[j*8 +: 8] = byte_val(seed, idx);
         end
         e.last = (w == nw - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic driveBeat(input logic [IN_B*8-1:0] data, input logic [IN_B-1:0] keep,
                            input logic last, output logic ok);
      logic rdy;
      phys_port.tvalid = 1'b1;
      phys_port.tdata  = data;
      phys_port.tkeep  = keep;
      phys_port.tlast  = last;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         rdy = phys_port.tready;
         @(posedge clk);
         #1;
         ok = rdy;
      end
      if (!ok) checkOutput("beat_accept_timeout", 256'(0), 256'(1));
   endtask

   task automatic applyStimulus(input int len, input int seed, input int bad_beat,
                                input logic [IN_B-1:0] bad_keep);
      int nb, rem, idx;
      logic [IN_B*8-1:0] d;
      logic [IN_B-1:0] k;
      logic ok;
      pushExpected(len, seed);
      nb = (len + IN_B - 1) / IN_B;
      for (int b = 0; b < nb; b++) begin
         rem = len - b * IN_B;
         for (int j = 0; j < IN_B; j++) begin
            idx = b * IN_B + j;
            d[j*8 +: 8] = (idx < len) ? byte_val(seed, idx) : 8'hA5;
         end
         k = '0;
         for (int j = 0; j < IN_B; j++) k[j] = (b != nb - 1) || (j < rem);
         if (b == bad_beat) k = bad_keep;
         driveBeat(d, k, b == nb - 1, ok);
         if (!ok) break;
      end
      phys_port.tvalid = 1'b0;
      phys_port.tlast  = 1'b0;
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         checkOutput("drain_timeout", 256'(exp_q.size()), 256'(0));
         exp_q.delete();
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: sampled mid-cycle so the next rising edge decides the handshake.
   always @(negedge clk) begin
      exp_word_t e;
      if (areset) begin
         held_valid = 1'b0;
      end else begin
         if (held_valid) begin
            checkOutput("o_stable_data", adapted.tdata, held_data);
            checkOutput("o_stable_ctrl", 256'({adapted.tvalid, adapted.tlast, adapted.tkeep}),
                        256'(held_ctrl));
         end
         held_valid = adapted.tvalid && !adapted.tready;
         held_data  = adapted.tdata;
         held_ctrl  = {adapted.tvalid, adapted.tlast, adapted.tkeep};
         if (adapted.tvalid && adapted.tready) begin
            words_seen++;
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_word", 256'(exp_q.size()), 256'(1));
            end else begin
               e = exp_q.pop_front();
               checkOutput("word_data", adapted.tdata, e.data);
               checkOutput("word_keep", 256'(adapted.tkeep), 256'(e.keep));
               checkOutput("word_last", 256'(adapted.tlast), 256'(e.last));
            end
         end
         if (keep_err) keep_err_seen++;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         adapted.tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      vec_t vecs[8];
      int w0, pk0, rn0;
      logic ok;

      vecs[0] = '{128, 1, 4, 0};
      vecs[1] = '{70,  2, 3, 0};
`ifdef P4_ROUTER_ING_RUNT_PAD_EN
      vecs[2] = '{20,  3, 2, 1};
      vecs[3] = '{64,  4, 2, 1};
      vecs[4] = '{8,   5, 2, 2};
      vecs[5] = '{33,  6, 2, 3};
      vecs[6] = '{32,  7, 2, 4};
      vecs[7] = '{63,  8, 2, 5};
`else
      vecs[2] = '{20,  3, 1, 1};
      vecs[3] = '{64,  4, 2, 1};
      vecs[4] = '{8,   5, 1, 2};
      vecs[5] = '{33,  6, 2, 3};
      vecs[6] = '{32,  7, 1, 4};
      vecs[7] = '{63,  8, 2, 5};
`endif

      areset = 1'b1;
      phys_port.tvalid = 1'b0;
      phys_port.tlast  = 1'b0;
      phys_port.tdata  = '0;
      phys_port.tkeep  = '0;
      phys_port.tstrb  = '1;
      phys_port.tid    = '0;
      phys_port.tdest  = '0;
      phys_port.tuser  = '0;
      adapted.tready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_tvalid", 256'(adapted.tvalid), 256'(0));
      checkOutput("rst_tdata", adapted.tdata, 256'(0));
      checkOutput("rst_tkeep", 256'(adapted.tkeep), 256'(0));
      checkOutput("rst_pkt_cnt", 256'(pkt_cnt), 256'(0));
      checkOutput("rst_runt_cnt", 256'(runt_cnt), 256'(0));
      checkOutput("rst_keep_err", 256'(keep_err), 256'(0));
      areset = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 8; v++) begin
         w0 = words_seen;
         applyStimulus(vecs[v].len, vecs[v].seed, -1, '0);
         waitDrain();
         checkOutput("vec_words", 256'(words_seen - w0), 256'(vecs[v].exp_words));
         checkOutput("vec_pkt_cnt", 256'(pkt_cnt), 256'(v + 1));
         checkOutput("vec_runt_cnt", 256'(runt_cnt), 256'(vecs[v].exp_runt_cnt));
      end

      // Partial tkeep on a non-last beat, then a non-contiguous tkeep on a last beat.
      keep_err_seen = 0;
      applyStimulus(16, 9, 0, 8'h0F);
      waitDrain();
      checkOutput("keep_err_nonlast", 256'(keep_err_seen), 256'(1));
      keep_err_seen = 0;
      applyStimulus(10, 10, 1, 8'h05);
      waitDrain();
      checkOutput("keep_err_last", 256'(keep_err_seen), 256'(1));
      checkOutput("keep_pkt_cnt", 256'(pkt_cnt), 256'(10));
      checkOutput("keep_runt_cnt", 256'(runt_cnt), 256'(7));

      // Random back-pressure across back-to-back packets.
      stall_mode = 1'b1;
      keep_err_seen = 0;
      pk0 = pkt_cnt;
      rn0 = runt_cnt;
      for (int p = 0; p < 4; p++) applyStimulus(64, 20 + p, -1, '0);
      applyStimulus(70, 30, -1, '0);
      applyStimulus(20, 31, -1, '0);
      waitDrain();
      stall_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("stall_pkt_cnt", 256'(pkt_cnt - pk0), 256'(6));
      checkOutput("stall_runt_cnt", 256'(runt_cnt - rn0), 256'(1));
      checkOutput("stall_keep_err", 256'(keep_err_seen), 256'(0));

      // Reset three beats into a packet; only the following packet may appear.
      for (int b = 0; b < 3; b++) driveBeat({8{8'(b + 1)}}, 8'hFF, 1'b0, ok);
      phys_port.tvalid = 1'b0;
      areset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      areset = 1'b0;
      checkOutput("mid_rst_pkt_cnt", 256'(pkt_cnt), 256'(0));
      checkOutput("mid_rst_tvalid", 256'(adapted.tvalid), 256'(0));
      @(posedge clk);
      #1;
      w0 = words_seen;
      applyStimulus(64, 40, -1, '0);
      waitDrain();
      checkOutput("post_rst_words", 256'(words_seen - w0), 256'(2));
      checkOutput("post_rst_pkt_cnt", 256'(pkt_cnt), 256'(1));
      checkOutput("post_rst_runt_cnt", 256'(runt_cnt), 256'(0));

      $display("[TB] %0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
